mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Word-addressed memory responder serving the datapath's memory-access port. The datapath issues a read or write request carrying a MAR address and MDR write data. This block holds a synchronous word array, inserts a fixed number of wait states, and returns read data plus a one-cycle done pulse. The datapath's MDMux consumes that read data as its memory-side input.

Parameters:
ADDR_W, 9, address width; array depth is 2**ADDR_W words
DATA_W, 32, word width
WAIT_CYCLES, 2, wait states inserted before the array access (0..15)
PROTECT_LIMIT, 16, number of low addresses that are write-protected (used only with MEM_WRITE_PROTECT_EN)

Ports:
clk  in  1  single system clock, rising edge
clr  in  1  reset, asynchronous, active-high
read_req  in  1  read request, sampled only in IDLE
write_req  in  1  write request, sampled only in IDLE
addr  in  ADDR_W  word address (MAR)
wdata  in  DATA_W  write data (MDR)
rdata  out  DATA_W  registered read data
busy  out  1  high from request acceptance until the cycle after done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle request-error pulse

Behaviour:
- Reset (clr=1, async): state=IDLE, counter=0, busy=0, done=0, err=0, rdata=0. Array contents are not cleared.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE: busy=0.
  - Edge with exactly one of read_req/write_req high: latch addr, wdata and op. Go to WAIT with cnt=WAIT_CYCLES-1, or go directly to ACCESS if WAIT_CYCLES=0. busy=1 from the next cycle.
  - Edge with both requests high: no access; err=1 for the next cycle only; stay in IDLE.
  - Edge with neither high: stay in IDLE.
- WAIT: at each edge, if cnt==0 go to ACCESS, else cnt--. WAIT lasts exactly WAIT_CYCLES cycles.
- ACCESS: at the edge:
  - write: mem[latched addr] <= latched wdata; rdata unchanged.
  - read: rdata <= mem[latched addr].
  - Then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle. rdata is valid here and is held until the next read completes. Next edge goes to IDLE.
- Latency: a request sampled at edge N produces done high in the cycle after edge N+WAIT_CYCLES+1. The earliest next request is sampled at edge N+WAIT_CYCLES+3.
- Requests and addr/wdata changes while busy=1 are ignored; they are not queued. Only the values latched at acceptance are used.
- Read-after-write to the same address returns the newly written word.
- Address wrap: addr is exactly ADDR_W bits, so no out-of-range case exists.
- clr asserted mid-operation aborts the operation. A write whose ACCESS edge has not yet occurred is discarded. done does not pulse.
- done and err are never high in the same cycle.

Optional Feature:
MEM_WRITE_PROTECT_EN
- Defined: a write to latched addr < PROTECT_LIMIT runs the full FSM sequence (IDLE, WAIT, ACCESS, DONE) but does not modify the array. err pulses in the DONE cycle instead of done. Reads are unaffected.
- Undefined: all addresses are writable. PROTECT_LIMIT is ignored. err is raised only for simultaneous requests.

Decomposition:
- Shared package mem_pkg: FSM state enum (IDLE/WAIT/ACCESS/DONE), op type (OP_READ/OP_WRITE), default ADDR_W/DATA_W constants.
- One sub-module, mem_array: single-port synchronous word RAM with we/addr/wdata/rdata and no reset. The FSM, counter and handshake stay in mem_responder.

Test Plan:
- Reset then idle: clr pulse mid-cycle -> rdata=0, busy=0, done=0, err=0 immediately (async).
- Write/read, WAIT_CYCLES=2: write addr=0x020 wdata=0xDEADBEEF at edge 0 -> done in the cycle after edge 3. Read 0x020 at edge 5 -> done in the cycle after edge 8 with rdata=0xDEADBEEF.
- Conflict: read_req=write_req=1 in IDLE -> err=1 for one cycle, busy stays 0, array unchanged.
- Ignored request: assert read_req with a new addr while busy=1 -> no extra done; rdata reflects only the accepted request.
- Abort: start write 0x55AA55AA to 0x030, assert clr during WAIT -> done never pulses; a later read of 0x030 returns the prior contents.
- MEM_WRITE_PROTECT_EN defined: write 0x12345678 to addr 0x005 -> err pulses in the DONE cycle, done stays 0; a read of 0x005 returns the old value. Undefined: the same write completes with done and the read returns 0x12345678.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, operation kind, default widths.
package mem_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, registered read port, no reset on storage.
// Read data changes only on a cycle with re set and holds otherwise.
module mem_array #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word memory responder: latches one request, waits WAIT_CYCLES, accesses the array, pulses done.
// Optional MEM_WRITE_PROTECT_EN blocks writes below PROTECT_LIMIT and reports them through err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WAIT_CYCLES   = 2,
  parameter int PROTECT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q;
  op_e               op_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              rd_vld_q;

  logic              prot;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_WRITE_PROTECT_EN
  assign prot = (op_q == OP_WRITE) && (32'(addr_q) < 32'(PROTECT_LIMIT));
`else
  logic unused_prot_limit;
  assign unused_prot_limit = (PROTECT_LIMIT != 0);
  assign prot = 1'b0;
`endif

  // Array strobes derive from state_q, so an async clr immediately cancels a pending access.
  assign ram_we = (state_q == ST_ACCESS) && (op_q == OP_WRITE) && !prot;
  assign ram_re = (state_q == ST_ACCESS) && (op_q == OP_READ);

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_READ;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (read_req ^ write_req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_q    <= write_req ? OP_WRITE : OP_READ;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_ACCESS;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else if (read_req && write_req) begin
            err_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_ACCESS: begin
          state_q <= ST_DONE;
          if (op_q == OP_READ) rd_vld_q <= 1'b1;
          done_q <= !prot;
          err_q  <= prot;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Before the first completed read since reset, present zero rather than stale RAM output.
  assign rdata = rd_vld_q ? ram_rdata : '0;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYCLES=2); expectation for the address-5 write follows MEM_WRITE_PROTECT_EN.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        read_req = 1'b0;
  logic        write_req = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W       (9),
    .DATA_W       (32),
    .WAIT_CYCLES  (2),
    .PROTECT_LIMIT(16)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .read_req (read_req),
    .write_req(write_req),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for exactly one sampling edge, returning 1ns after that edge.
  task automatic issue(input logic r, input logic w, input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    read_req  = r;
    write_req = w;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    #1;
    read_req  = 1'b0;
    write_req = 1'b0;
  endtask

  // Full transaction with cycle-exact checks: accepted at edge N, DONE cycle after edge N+3.
  task automatic run_op(input string tag, input logic r, input logic w, input logic [8:0] a,
                        input logic [31:0] d, input logic exp_done, input logic exp_err);
    issue(r, w, a, d);
    @(negedge clk);
    check({tag, "_busy_n0"}, 32'(busy), 32'd1);
    check({tag, "_done_n0"}, 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_n2"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_done_n3"}, 32'(done), 32'(exp_done));
    check({tag, "_err_n3"},  32'(err),  32'(exp_err));
    check({tag, "_busy_n3"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_n4"}, 32'(busy), 32'd0);
    check({tag, "_done_n4"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;

    // Async reset with no clock edge in between
    #2 clr = 1'b1;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Write then read back
    run_op("wr20", 1'b0, 1'b1, 9'h020, 32'hDEADBEEF, 1'b1, 1'b0);
    check("wr20_rdata_unchanged", rdata, 32'h0);
    run_op("rd20", 1'b1, 1'b0, 9'h020, 32'h0, 1'b1, 1'b0);
    check("rd20_rdata", rdata, 32'hDEADBEEF);

    // Conflicting requests
    issue(1'b1, 1'b1, 9'h020, 32'h0BADF00D);
    @(negedge clk);
    check("conf_err", 32'(err), 32'd1);
    check("conf_busy", 32'(busy), 32'd0);
    check("conf_done", 32'(done), 32'd0);
    @(negedge clk);
    check("conf_err_clear", 32'(err), 32'd0);
    run_op("conf_rd", 1'b1, 1'b0, 9'h020, 32'h0, 1'b1, 1'b0);
    check("conf_rd_rdata", rdata, 32'hDEADBEEF);

    // Request held while busy is ignored
    run_op("wr40", 1'b0, 1'b1, 9'h040, 32'h11111111, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 9'h020, 32'h0);
    read_req = 1'b1;
    addr     = 9'h040;
    ndone    = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (i == 2) read_req = 1'b0;
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_rdata", rdata, 32'hDEADBEEF);
    run_op("rd40", 1'b1, 1'b0, 9'h040, 32'h0, 1'b1, 1'b0);
    check("rd40_rdata", rdata, 32'h11111111);

    // Abort a write during WAIT
    run_op("wr30", 1'b0, 1'b1, 9'h030, 32'hA5A5A5A5, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 9'h030, 32'h55AA55AA);
    #2 clr = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'h0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (i == 1) clr = 1'b0;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op("rd30", 1'b1, 1'b0, 9'h030, 32'h0, 1'b1, 1'b0);
    check("rd30_rdata", rdata, 32'hA5A5A5A5);

    // Write to a low address
`ifdef MEM_WRITE_PROTECT_EN
    run_op("wr05", 1'b0, 1'b1, 9'h005, 32'h12345678, 1'b0, 1'b1);
    run_op("rd05", 1'b1, 1'b0, 9'h005, 32'h0, 1'b1, 1'b0);
    check("rd05_not_written", 32'(rdata !== 32'h12345678), 32'd1);
`else
    run_op("wr05", 1'b0, 1'b1, 9'h005, 32'h12345678, 1'b1, 1'b0);
    run_op("rd05", 1'b1, 1'b0, 9'h005, 32'h0, 1'b1, 1'b0);
    check("rd05_rdata", rdata, 32'h12345678);
`endif

    // Overwrite then read the same address
    run_op("wr20b", 1'b0, 1'b1, 9'h020, 32'hCAFE0001, 1'b1, 1'b0);
    run_op("rd20b", 1'b1, 1'b0, 9'h020, 32'h0, 1'b1, 1'b0);
    check("rd20b_rdata", rdata, 32'hCAFE0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
